// File: rtl/gelu_vec.sv
// gelu_vec: multi-lane I-BERT integer GELU / erf-only datapath.
// The input register and seven compute stages advance together under one
// global advance signal. The active coefficients only change while the
// pipeline is empty, so later stages read them directly.
module gelu_vec #(
  parameter int LANES = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 32,
  parameter int SHIFT = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*IN_W-1:0]  s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*OUT_W-1:0] m_data,
  output logic                   m_last,
  output logic [LANES-1:0]       m_sat,
  input  logic                   cfg_we,
  input  logic [IN_W-1:0]        cfg_qb,
  input  logic [IN_W-1:0]        cfg_qc,
  input  logic [IN_W-1:0]        cfg_q1,
  input  logic                   cfg_mode,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int TW  = IN_W + 3;       // qmin and qmin + 2*qb
  localparam int QLW = 2*IN_W + 2;     // polynomial ql
  localparam int PW  = 2*TW;           // raw product before trimming to QLW
  localparam int EW  = QLW + 1;        // sign-applied, shifted polynomial
  localparam int RW  = EW + 1 + IN_W;  // x * (qerf + q1)

  localparam logic signed [RW-1:0]   OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0]   OMIN = ~OMAX;
  localparam logic signed [IN_W-1:0] XMAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] XMIN = ~XMAX;

  // active configuration
  logic signed [IN_W-1:0] qb_q, qc_q, q1_q;
  logic                   mode_q;
  logic                   cfg_err_q;

  // stage valid / last shift chain; bit 7 is the output register
  logic [7:0] vld_q, last_q;
  logic       adv;

  // per-stage datapath registers
  logic signed [IN_W-1:0]  x_q     [6][LANES];
  logic [LANES-1:0]        neg_q   [4];
  logic signed [IN_W-1:0]  a1_q    [LANES];
  logic signed [TW-1:0]    qmin2_q [LANES];
  logic signed [TW-1:0]    qmin3_q [LANES];
  logic signed [TW-1:0]    t3_q    [LANES];
  logic signed [QLW-1:0]   ql4_q   [LANES];
  logic signed [EW-1:0]    qe5_q   [LANES];
  logic signed [RW-1:0]    r6_q    [LANES];
  logic signed [OUT_W-1:0] out_q   [LANES];
  logic [LANES-1:0]        sat_q;

  // next-state values
  logic [LANES-1:0]        neg1_d;
  logic signed [IN_W-1:0]  a1_d    [LANES];
  logic signed [TW-1:0]    qmin2_d [LANES];
  logic signed [TW-1:0]    t3_d    [LANES];
  logic signed [QLW-1:0]   ql4_d   [LANES];
  logic signed [EW-1:0]    qe5_d   [LANES];
  logic signed [RW-1:0]    r6_d    [LANES];
  logic signed [OUT_W-1:0] out7_d  [LANES];
  logic [LANES-1:0]        sat7_d;

  logic signed [TW-1:0] nqb, qb2;

  assign adv     = !vld_q[7] || m_ready;
  assign s_ready = adv;
  assign busy    = |vld_q;
  assign m_valid = vld_q[7];
  assign m_last  = last_q[7];
  assign m_sat   = sat_q;
  assign cfg_err = cfg_err_q;
  assign nqb     = -TW'(qb_q);
  assign qb2     = TW'(qb_q) <<< 1;

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign m_data[g*OUT_W +: OUT_W] = out_q[g];
  end

  // Coefficient load only when no beat is in flight; a busy write is flagged for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      qb_q      <= '0;
      qc_q      <= '0;
      q1_q      <= '0;
      mode_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && busy;
      if (cfg_we && !busy) begin
        qb_q   <= cfg_qb;
        qc_q   <= cfg_qc;
        q1_q   <= cfg_q1;
        mode_q <= cfg_mode;
      end
    end
  end

  // Per-lane arithmetic for each stage, full precision until the final clip.
  always_comb begin
    neg1_d = '0;
    sat7_d = '0;
    for (int i = 0; i < LANES; i++) begin
      neg1_d[i]  = x_q[0][i][IN_W-1];
      a1_d[i]    = !x_q[0][i][IN_W-1] ? x_q[0][i] :
                   (x_q[0][i] == XMIN) ? XMAX : -x_q[0][i];
      qmin2_d[i] = (TW'(a1_q[i]) < nqb) ? TW'(a1_q[i]) : nqb;
      t3_d[i]    = qmin2_q[i] + qb2;
      ql4_d[i]   = QLW'(PW'(t3_q[i]) * PW'(qmin3_q[i])) + QLW'(qc_q);
      qe5_d[i]   = (neg_q[3][i] ? -EW'(ql4_q[i]) : EW'(ql4_q[i])) >>> SHIFT;
      r6_d[i]    = mode_q ? RW'(qe5_q[i])
                          : RW'(x_q[5][i]) * (RW'(qe5_q[i]) + RW'(q1_q));
      if (r6_q[i] > OMAX) begin
        out7_d[i] = OMAX[OUT_W-1:0];
        sat7_d[i] = 1'b1;
      end else if (r6_q[i] < OMIN) begin
        out7_d[i] = OMIN[OUT_W-1:0];
        sat7_d[i] = 1'b1;
      end else begin
        out7_d[i] = r6_q[i][OUT_W-1:0];
      end
    end
  end

  // Control chain and output register; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
      sat_q  <= '0;
      for (int i = 0; i < LANES; i++) out_q[i] <= '0;
    end else if (adv) begin
      vld_q  <= {vld_q[6:0], s_valid};
      last_q <= {last_q[6:0], s_last};
      sat_q  <= sat7_d;
      for (int i = 0; i < LANES; i++) out_q[i] <= out7_d[i];
    end
  end

  // Datapath stages; contents behind an invalid stage are don't-care.
  always_ff @(posedge clk) begin
    if (adv) begin
      neg_q[0] <= neg1_d;
      for (int k = 1; k < 4; k++) neg_q[k] <= neg_q[k-1];
      for (int i = 0; i < LANES; i++) begin
        x_q[0][i] <= s_data[i*IN_W +: IN_W];
        for (int k = 1; k < 6; k++) x_q[k][i] <= x_q[k-1][i];
        a1_q[i]    <= a1_d[i];
        qmin2_q[i] <= qmin2_d[i];
        qmin3_q[i] <= qmin2_q[i];
        t3_q[i]    <= t3_d[i];
        ql4_q[i]   <= ql4_d[i];
        qe5_q[i]   <= qe5_d[i];
        r6_q[i]    <= r6_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gelu_vec.sv
// Bench for gelu_vec: hand-computed vector table, randomized backpressured
// streams against a wide-integer reference model, config-while-busy and
// mid-stream reset sequences.
module tb_gelu_vec;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 2;
  localparam int DW    = LANES*OUT_W;

  typedef struct packed {
    logic signed [31:0] qb;
    logic signed [31:0] qc;
    logic signed [31:0] q1;
    logic               mode;
  } cfg_t;

  typedef struct packed {
    cfg_t                  c;
    logic [LANES*IN_W-1:0] x;
    logic [DW-1:0]         y;
    logic [LANES-1:0]      s;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0]    d;
    logic [LANES-1:0] s;
    logic             l;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid, s_ready, s_last;
  logic [LANES*IN_W-1:0] s_data;
  logic                  m_valid, m_ready, m_last;
  logic [DW-1:0]         m_data;
  logic [LANES-1:0]      m_sat;
  logic                  cfg_we, cfg_mode, cfg_err, busy;
  logic [IN_W-1:0]       cfg_qb, cfg_qc, cfg_q1;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tbl[6];

  gelu_vec #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_sat(m_sat),
    .cfg_we(cfg_we), .cfg_qb(cfg_qb), .cfg_qc(cfg_qc), .cfg_q1(cfg_q1), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  function automatic cfg_t mk_cfg(input int qb, input int qc, input int q1, input logic mode);
    cfg_t c;
    c.qb = qb; c.qc = qc; c.q1 = q1; c.mode = mode;
    return c;
  endfunction

  function automatic logic [LANES*IN_W-1:0] pack_in(input int a, input int b, input int c, input int d);
    return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction

  function automatic logic [DW-1:0] pack_out(input int a, input int b, input int c, input int d);
    return {OUT_W'(d), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
  endfunction

  function automatic vec_t mk_row(input cfg_t c, input logic [LANES*IN_W-1:0] x,
                                  input logic [DW-1:0] y, input logic [LANES-1:0] s);
    vec_t v;
    v.c = c; v.x = x; v.y = y; v.s = s;
    return v;
  endfunction

  // Reference: the GELU/erf rules evaluated in wide signed integers.
  function automatic void model(input logic signed [IN_W-1:0] x, input cfg_t c,
                                output logic [OUT_W-1:0] y, output logic s);
    logic signed [127:0] xs, a, qm, ql, qe, r, lim, qb;
    xs = 128'(x);
    qb = 128'($signed(c.qb));
    a  = (xs < 0) ? -xs : xs;
    lim = (128'sd1 <<< (IN_W-1)) - 1;
    if (a > lim) a = lim;
    qm = (a < -qb) ? a : -qb;
    ql = (qm + 2*qb) * qm + 128'($signed(c.qc));
    ql = 128'($signed(ql[2*IN_W+1:0]));
    if (xs < 0) ql = -ql;
    qe = ql >>> SHIFT;
    r  = c.mode ? qe : xs * (qe + 128'($signed(c.q1)));
    lim = 128'sd1 <<< (OUT_W-1);
    s = 1'b1;
    if (r >= lim)      y = OUT_W'(lim - 1);
    else if (r < -lim) y = OUT_W'(-lim);
    else begin
      y = OUT_W'(r);
      s = 1'b0;
    end
  endfunction

  function automatic exp_t model_beat(input logic [LANES*IN_W-1:0] xv, input cfg_t c, input logic last);
    exp_t e;
    logic [OUT_W-1:0] y;
    logic s;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      model(xv[i*IN_W +: IN_W], c, y, s);
      e.d[i*OUT_W +: OUT_W] = y;
      e.s[i] = s;
    end
    e.l = last;
    return e;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_x();
    logic [LANES*IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*IN_W +: IN_W] = $urandom;
        1:       v[i*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 6000)) - 3000);
        default: v[i*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 80)) - 40);
      endcase
    end
    return v;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_qb = c.qb; cfg_qc = c.qc; cfg_q1 = c.q1; cfg_mode = c.mode;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!m_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Config write and beat in the same cycle, then latency and result checks.
  task automatic run_row(input int idx);
    int k;
    drive_cfg(tbl[idx].c);
    cfg_we = 1'b1; s_valid = 1'b1; s_data = tbl[idx].x; s_last = (idx % 2) == 1;
    @(posedge clk); #1;
    cfg_we = 1'b0; s_valid = 1'b0;
    check($sformatf("row%0d_cfg_err", idx), 64'(cfg_err), 64'(0));
    wait_valid(k);
    check($sformatf("row%0d_latency", idx), 64'(k), 64'(7));
    check($sformatf("row%0d_data", idx), m_data, tbl[idx].y);
    check($sformatf("row%0d_sat", idx), 64'(m_sat), 64'(tbl[idx].s));
    check($sformatf("row%0d_last", idx), 64'(m_last), 64'((idx % 2) == 1));
    @(posedge clk); #1;
    check($sformatf("row%0d_idle", idx), 64'(busy), 64'(0));
  endtask

  task automatic run_stream(input cfg_t c, input int nbeats);
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0;
    logic [LANES*IN_W-1:0] xv;
    logic stall_prev = 1'b0;
    logic [DW-1:0] stall_d = '0;
    logic [LANES-1:0] stall_s = '0;
    drive_cfg(c);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    xv = rand_x();
    while ((sent < nbeats || got < nbeats) && cyc < 600) begin
      m_ready = ($urandom_range(0, 2) != 0);
      s_valid = (sent < nbeats);
      s_data  = xv;
      s_last  = xv[0];
      #1;
      check("stream_s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
      if (stall_prev) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", m_data, stall_d);
        check("stall_sat", 64'(m_sat), 64'(stall_s));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("stream_extra_beat", 64'(got + 1), 64'(sent));
        else begin
          e = q.pop_front();
          check("stream_data", m_data, e.d);
          check("stream_sat", 64'(m_sat), 64'(e.s));
          check("stream_last", 64'(m_last), 64'(e.l));
        end
        got++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = m_valid;
        stall_d    = m_data;
        stall_s    = m_sat;
      end
      if (s_valid && s_ready) begin
        q.push_back(model_beat(xv, c, xv[0]));
        sent++;
        xv = rand_x();
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("stream_count", 64'(got), 64'(nbeats));
    check("stream_drained", 64'(busy), 64'(0));
  endtask

  initial begin
    int k, nv;
    cfg_t c;
    exp_t e;
    logic [LANES*IN_W-1:0] xv;

    tbl[0] = mk_row(mk_cfg(-4, 16, 4, 1'b0), pack_in(2, -2, 10, 0),
                    pack_out(10, -6, 40, 0), 4'b0000);
    tbl[1] = mk_row(mk_cfg(-4, 16, 4, 1'b1), pack_in(2, -2, 10, 0),
                    pack_out(1, -1, 0, 4), 4'b0000);
    tbl[2] = mk_row(mk_cfg(-4, 16, 4, 1'b0),
                    pack_in(10000, -10000, int'(32'h8000_0000), int'(32'h7fff_ffff)),
                    pack_out(32767, -32768, -32768, 32767), 4'b1111);
    tbl[3] = mk_row(mk_cfg(-4, 16, 4, 1'b0), pack_in(8191, 8192, -8192, -8193),
                    pack_out(32764, 32767, -32768, -32768), 4'b1010);
    tbl[4] = mk_row(mk_cfg(-100, 1000, 0, 1'b1), pack_in(50, -50, 200, 0),
                    pack_out(-1625, 1625, -2250, 250), 4'b0000);
    tbl[5] = mk_row(mk_cfg(-4, 17, 0, 1'b1), pack_in(0, -1, 1, 3),
                    pack_out(4, -3, 2, 0), 4'b0000);

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b0; drive_cfg(mk_cfg(0, 0, 0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_m_data", m_data, 64'(0));
    check("rst_m_sat", 64'(m_sat), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_cfg_err", 64'(cfg_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_s_ready", 64'(s_ready), 64'(1));

    for (int r = 0; r < 6; r++) run_row(r);

    // Write while busy: rejected with a one-cycle error, old coefficients stay.
    drive_cfg(tbl[0].c);
    cfg_we = 1'b1; s_valid = 1'b1; s_data = tbl[0].x; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
    drive_cfg(tbl[4].c);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_err_pulse", 64'(cfg_err), 64'(1));
    @(posedge clk); #1;
    check("cfg_err_clear", 64'(cfg_err), 64'(0));
    wait_valid(k);
    check("busy_write_valid", 64'(m_valid), 64'(1));
    check("busy_write_old_cfg", m_data, tbl[0].y);
    @(posedge clk); #1;

    run_stream(mk_cfg(-int'($urandom_range(0, 300)), int'($urandom_range(0, 10000)) - 5000,
                      int'($urandom_range(0, 1000)) - 500, 1'b0), 20);
    run_stream(mk_cfg(-int'($urandom_range(0, 300)), int'($urandom_range(0, 10000)) - 5000,
                      int'($urandom_range(0, 1000)) - 500, 1'b1), 20);

    // Reset with five beats in flight.
    drive_cfg(mk_cfg(-4, 16, 4, 1'b1));
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    for (int b = 0; b < 5; b++) begin
      s_valid = 1'b1; s_data = rand_x(); s_last = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("inflight_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_m_data", m_data, 64'(0));
    check("midrst_m_last", 64'(m_last), 64'(0));
    xv = pack_in(0, 1, -1, 2);
    e  = model_beat(xv, mk_cfg(0, 0, 0, 1'b0), 1'b1);
    s_valid = 1'b1; s_data = xv; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    nv = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (m_valid) begin
        nv++;
        check("post_rst_data", m_data, e.d);
        check("post_rst_last", 64'(m_last), 64'(e.l));
      end
    end
    check("post_rst_beats", 64'(nv), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gelu_vec.md
Name: gelu_vec

Overview:
- Multi-lane, backpressure-aware successor to the single-lane integer GELU.
- Computes I-BERT integer GELU (or erf-only) on LANES signed samples per beat through a fixed-depth pipeline.
- Sits between the FFN matmul requantiser and the next requantiser, using AXI-Stream-style valid/ready on both sides.
- Adds run-time coefficient loading, mode select, output saturation and last-flag passthrough.

Parameters:
LANES, 4, parallel samples per beat
IN_W, 32, signed input sample width
OUT_W, 32, signed output sample width (OUT_W <= 2*IN_W)
SHIFT, 14, arithmetic right shift applied to erf polynomial

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  LANES*IN_W  packed signed samples, lane i at [i*IN_W +: IN_W]
s_last  in  1  end-of-row marker, travels with beat
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  LANES*OUT_W  packed signed results
m_last  out  1  delayed s_last
m_sat  out  LANES  per-lane saturation flag for current m_data beat
cfg_we  in  1  coefficient write strobe
cfg_qb, cfg_qc, cfg_q1  in  IN_W each  signed coefficients b, c, 1 (scaled)
cfg_mode  in  1  0 = GELU, 1 = erf only
cfg_err  out  1  one-cycle pulse: cfg_we dropped because busy
busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset: m_valid, m_data, m_last, m_sat, cfg_err, busy = 0. All active coefficients and mode = 0. All in-flight beats are discarded, including on reset mid-operation.
- Pipeline: 7 stages with a global advance signal adv = !m_valid || m_ready.
  - s_ready = adv (combinational from m_ready).
  - When adv = 0, every stage holds. m_data, m_last and m_sat stay stable while m_valid && !m_ready.
  - Latency: a beat accepted at edge N appears with m_valid = 1 after edge N+7 when m_ready is held 1. Throughput is one beat per cycle.
  - Bubbles (s_valid = 0) propagate as invalid stages. Downstream never sees duplicates or drops.
- Per-lane arithmetic, full precision internally, no intermediate wrap:
  - sgn = -1 if x < 0, else +1.
  - a = |x|. x = -2^(IN_W-1) gives a = 2^(IN_W-1)-1.
  - qmin = min(a, -qb).
  - ql = (qmin + 2*qb)*qmin + qc, held in 2*IN_W+2 bits.
  - qerf = (sgn*ql) >>> SHIFT (arithmetic, floor).
  - Result r = qerf when mode = 1; r = x*(qerf + q1) when mode = 0.
  - Output: r saturated to signed OUT_W. m_sat[i] = 1 iff lane i was clipped.
- Configuration:
  - cfg_we honoured only when busy = 0: qb, qc, q1 and mode are registered into the active set.
  - A beat accepted in the same cycle as an honoured cfg_we uses the new values.
  - cfg_we while busy = 1: write ignored, cfg_err = 1 next cycle for exactly one cycle.
- busy = OR of stage valids, including the output register while m_valid.

Test Plan:
- Cfg SHIFT=2, qb=-4, qc=16, q1=4, mode 0. Lanes x = {2,-2,10,0}, m_ready=1 -> after 7 cycles m_data = {10,-6,40,0}, m_sat=0, m_last equals input.
- Same cfg, mode 1, x=2 -> 1; x=-2 -> -1. No saturation.
- OUT_W=8, mode 0, x = {100,-100} -> {127,-128}, m_sat bits = 1.
- Stream 20 back-to-back beats, toggle m_ready pseudo-randomly -> outputs in order, no loss or duplication, m_data stable while stalled, s_ready == (!m_valid || m_ready).
- cfg_we while busy -> cfg_err pulses 1 cycle, old coefficients still used. cfg_we when idle together with an accepted beat -> that beat uses the new coefficients.
- Assert rst with 5 beats in flight -> next cycle m_valid=0, busy=0, coefficients=0. No stale beat emerges afterwards.
